// File: rtl/i2c_slave_pkg.sv
// Shared widths, constants and FSM state type for the I2C slave sequencer.
package i2c_slave_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;
    localparam logic [I2C_ADDR_W-1:0] GENCALL_ADDR = 7'h00;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StRx,
        StRxAck,
        StTx,
        StTxAck
    } i2c_state_e;

endpackage

// File: rtl/i2c_shift8.sv
// Byte-wide shift register with parallel load, serial shift-in (LSB side) and MSB output.
module i2c_shift8
    import i2c_slave_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_an,
    input  logic                  i_load,
    input  logic [I2C_BYTE_W-1:0] i_data,
    input  logic                  i_shift,
    input  logic                  i_bit,
    output logic [I2C_BYTE_W-1:0] o_q,
    output logic                  o_msb
);

    logic [I2C_BYTE_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= {r_q[I2C_BYTE_W-2:0], i_bit};
        end
    end

    assign o_q   = r_q;
    assign o_msb = r_q[I2C_BYTE_W-1];

endmodule

// File: rtl/i2c_slave_seq.sv
// Bit/byte sequencer for a 7-bit-address I2C slave.
// Define I2C_GENCALL_EN to also accept the general-call write address (8'h00).
module i2c_slave_seq
    import i2c_slave_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic                  clk,
    input  logic                  rst_an,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  sclRise,
    input  logic                  sclFall,
    input  logic                  sda,
    output logic                  sdaOe,
    output logic [I2C_BYTE_W-1:0] rxData,
    output logic                  rxValid,
    input  logic [I2C_BYTE_W-1:0] txData,
    output logic                  txLoad,
    output logic                  rnw,
    output logic                  busy
);

    i2c_state_e            r_state, w_state_d;
    logic [2:0]            r_bit_cnt, w_bit_cnt_d;
    logic                  r_done, w_done_d;  // 8 bits of the current byte seen, or ACK sampled
    logic                  r_sda_oe, w_sda_oe_d;
    logic                  r_rnw, w_rnw_d;
    logic [I2C_BYTE_W-1:0] r_rx_data, w_rx_data_d;
    logic                  r_rx_valid, w_rx_valid_d;
    logic                  w_rx_shift, w_tx_shift, w_tx_load;
    logic [I2C_BYTE_W-1:0] w_rx_q, w_tx_q, w_byte;
    logic                  w_rx_msb, w_tx_msb, w_match;
    logic                  w_unused;

    i2c_shift8 u_rx_shift (
        .clk    (clk),
        .rst_an (rst_an),
        .i_load (1'b0),
        .i_data ('0),
        .i_shift(w_rx_shift),
        .i_bit  (sda),
        .o_q    (w_rx_q),
        .o_msb  (w_rx_msb)
    );

    i2c_shift8 u_tx_shift (
        .clk    (clk),
        .rst_an (rst_an),
        .i_load (w_tx_load),
        .i_data (txData),
        .i_shift(w_tx_shift),
        .i_bit  (1'b0),
        .o_q    (w_tx_q),
        .o_msb  (w_tx_msb)
    );

    assign w_unused = ^{w_rx_msb, w_rx_q[I2C_BYTE_W-1], w_tx_q};

    // Complete byte as it will stand once the bit on the current sclRise is shifted in.
    assign w_byte = {w_rx_q[I2C_BYTE_W-2:0], sda};

`ifdef I2C_GENCALL_EN
    assign w_match = (w_byte[I2C_BYTE_W-1:1] == SLAVE_ADDR) ||
                     (w_byte == {GENCALL_ADDR, 1'b0});
`else
    assign w_match = (w_byte[I2C_BYTE_W-1:1] == SLAVE_ADDR);
`endif

    always_comb begin
        w_state_d    = r_state;
        w_bit_cnt_d  = r_bit_cnt;
        w_done_d     = r_done;
        w_sda_oe_d   = r_sda_oe;
        w_rnw_d      = r_rnw;
        w_rx_data_d  = r_rx_data;
        w_rx_valid_d = 1'b0;
        w_rx_shift   = 1'b0;
        w_tx_shift   = 1'b0;
        w_tx_load    = 1'b0;

        if (stop) begin
            w_state_d  = StIdle;
            w_sda_oe_d = 1'b0;
            w_done_d   = 1'b0;
        end else if (start) begin
            w_state_d   = StAddr;
            w_bit_cnt_d = 3'd0;
            w_sda_oe_d  = 1'b0;
            w_done_d    = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: ;
                StAddr: begin
                    if (sclRise && !r_done) begin
                        w_rx_shift  = 1'b1;
                        w_bit_cnt_d = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_match) begin
                                w_done_d = 1'b1;
                                w_rnw_d  = w_byte[0];
                            end else begin
                                w_state_d = StIdle;
                            end
                        end
                    end else if (sclFall && r_done) begin
                        w_sda_oe_d = 1'b1;
                        w_done_d   = 1'b0;
                        w_state_d  = StAddrAck;
                    end
                end
                StAddrAck: begin
                    if (sclRise && r_rnw) begin
                        w_tx_load = 1'b1;
                    end else if (sclFall) begin
                        w_bit_cnt_d = 3'd0;
                        w_sda_oe_d  = r_rnw ? ~w_tx_msb : 1'b0;
                        w_state_d   = r_rnw ? StTx : StRx;
                    end
                end
                StRx: begin
                    if (sclRise && !r_done) begin
                        w_rx_shift  = 1'b1;
                        w_bit_cnt_d = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_rx_data_d  = w_byte;
                            w_rx_valid_d = 1'b1;
                            w_done_d     = 1'b1;
                        end
                    end else if (sclFall && r_done) begin
                        w_sda_oe_d = 1'b1;
                        w_done_d   = 1'b0;
                        w_state_d  = StRxAck;
                    end
                end
                StRxAck: begin
                    if (sclFall) begin
                        w_sda_oe_d  = 1'b0;
                        w_bit_cnt_d = 3'd0;
                        w_state_d   = StRx;
                    end
                end
                StTx: begin
                    // Advance on sclRise, after the master has sampled; drive on the next fall.
                    if (sclRise && !r_done) begin
                        w_tx_shift  = 1'b1;
                        w_bit_cnt_d = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_done_d = 1'b1;
                        end
                    end else if (sclFall) begin
                        if (r_done) begin
                            w_sda_oe_d = 1'b0;
                            w_done_d   = 1'b0;
                            w_state_d  = StTxAck;
                        end else begin
                            w_sda_oe_d = ~w_tx_msb;
                        end
                    end
                end
                StTxAck: begin
                    if (sclRise && !r_done) begin
                        if (!sda) begin
                            w_tx_load = 1'b1;
                            w_done_d  = 1'b1;
                        end else begin
                            w_state_d  = StIdle;
                            w_sda_oe_d = 1'b0;
                        end
                    end else if (sclFall && r_done) begin
                        w_sda_oe_d  = ~w_tx_msb;
                        w_done_d    = 1'b0;
                        w_bit_cnt_d = 3'd0;
                        w_state_d   = StTx;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            r_state    <= StIdle;
            r_bit_cnt  <= 3'd0;
            r_done     <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rnw      <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_done     <= w_done_d;
            r_sda_oe   <= w_sda_oe_d;
            r_rnw      <= w_rnw_d;
            r_rx_data  <= w_rx_data_d;
            r_rx_valid <= w_rx_valid_d;
        end
    end

    assign sdaOe   = r_sda_oe;
    assign rxData  = r_rx_data;
    assign rxValid = r_rx_valid;
    assign txLoad  = w_tx_load;
    assign rnw     = r_rnw;
    assign busy    = (r_state != StIdle);

endmodule
